// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: four per-unit result FIFOs drained one result per
// cycle by a round-robin arbiter into a registered CDB broadcast.

module cdb_fifo #(
    parameter int W     = 38,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;

    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(DEPTH));
    assign head  = mem[rd_ptr];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module cdb_arbiter #(
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_int_valid,
    input  logic [TAG_W-1:0]  i_int_tag,
    input  logic [DATA_W-1:0] i_int_data,
    output logic              o_int_ready,
    input  logic              i_mult_valid,
    input  logic [TAG_W-1:0]  i_mult_tag,
    input  logic [DATA_W-1:0] i_mult_data,
    output logic              o_mult_ready,
    input  logic              i_div_valid,
    input  logic [TAG_W-1:0]  i_div_tag,
    input  logic [DATA_W-1:0] i_div_data,
    output logic              o_div_ready,
    input  logic              i_mem_valid,
    input  logic [TAG_W-1:0]  i_mem_tag,
    input  logic [DATA_W-1:0] i_mem_data,
    output logic              o_mem_ready,
    output logic              o_cdb_valid,
    output logic [TAG_W-1:0]  o_cdb_tag,
    output logic [DATA_W-1:0] o_cdb_data,
    output logic [1:0]        o_cdb_src,
    output logic              o_busy
);
    localparam int N = 4;
    localparam int W = TAG_W + DATA_W;

    logic [N-1:0]        valid, push, pop, empty, full, req;
    logic [N-1:0][W-1:0] din, head;
    logic [1:0]          rr, grant, cand;
    logic                any;

    assign valid = {i_mem_valid, i_div_valid, i_mult_valid, i_int_valid};
    assign din   = {{i_mem_tag, i_mem_data}, {i_div_tag, i_div_data},
                    {i_mult_tag, i_mult_data}, {i_int_tag, i_int_data}};

    // Ready looks only at stored occupancy, so a full FIFO stays closed even
    // in a cycle where it is being popped.
    assign o_int_ready  = ~full[0];
    assign o_mult_ready = ~full[1];
    assign o_div_ready  = ~full[2];
    assign o_mem_ready  = ~full[3];
    assign push = valid & ~full & {N{~i_flush}};

    generate
        for (genvar u = 0; u < N; u++) begin : g_fifo
            cdb_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
                .clk   (i_clk),
                .rst   (i_rst),
                .flush (i_flush),
                .push  (push[u]),
                .din   (din[u]),
                .pop   (pop[u]),
                .head  (head[u]),
                .empty (empty[u]),
                .full  (full[u])
            );
        end
    endgenerate

    assign req    = ~empty;
    assign o_busy = |req;

    always_comb begin
        grant = rr;
        any   = 1'b0;
        cand  = rr;
        pop   = '0;
        for (int i = 0; i < N; i++) begin
            cand = rr + 2'(i);
            if (!any && req[cand]) begin
                grant = cand;
                any   = 1'b1;
            end
        end
        if (any && !i_flush)
            pop[grant] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr          <= '0;
            o_cdb_valid <= 1'b0;
            o_cdb_tag   <= '0;
            o_cdb_data  <= '0;
            o_cdb_src   <= '0;
        end else if (i_flush) begin
            rr          <= '0;
            o_cdb_valid <= 1'b0;
        end else if (any) begin
            o_cdb_valid             <= 1'b1;
            {o_cdb_tag, o_cdb_data} <= head[grant];
            o_cdb_src               <= grant;
            rr                      <= grant + 2'd1;
        end else begin
            o_cdb_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed streams with hand-ordered
// expected CDB broadcasts, checked by an independent monitor.

module tb_cdb_arbiter;
    typedef struct {
        logic [1:0]  src;
        logic [5:0]  tag;
        logic [31:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst, flush;
    logic [3:0]        valid;
    logic [3:0][5:0]   tag;
    logic [3:0][31:0]  data;
    logic [3:0]        rdy;
    logic              cdb_valid, busy;
    logic [5:0]        cdb_tag;
    logic [31:0]       cdb_data;
    logic [1:0]        cdb_src;

    exp_t        sb[$];
    int          total = 0, passed = 0;
    int          src_cnt[4];
    logic [5:0]  ftag[4][16];
    logic [31:0] fdata[4][16];
    int          flen[4], fidx[4];

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_int_valid(valid[0]),  .i_int_tag(tag[0]),  .i_int_data(data[0]),  .o_int_ready(rdy[0]),
        .i_mult_valid(valid[1]), .i_mult_tag(tag[1]), .i_mult_data(data[1]), .o_mult_ready(rdy[1]),
        .i_div_valid(valid[2]),  .i_div_tag(tag[2]),  .i_div_data(data[2]),  .o_div_ready(rdy[2]),
        .i_mem_valid(valid[3]),  .i_mem_tag(tag[3]),  .i_mem_data(data[3]),  .o_mem_ready(rdy[3]),
        .o_cdb_valid(cdb_valid), .o_cdb_tag(cdb_tag), .o_cdb_data(cdb_data),
        .o_cdb_src(cdb_src), .o_busy(busy)
    );

    function automatic logic [31:0] mkdata(input int u, input int t);
        return 32'h5A00_0000 | (u << 16) | t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every broadcast must match the head of the scoreboard.
    always @(negedge clk) begin
        if (cdb_valid) begin
            total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_bcast: got src %0d tag %0d expected none", cdb_src, cdb_tag);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cdb_src === e.src && cdb_tag === e.tag && cdb_data === e.data) passed++;
                else $display("FAIL bcast: got src %0d tag %0d data %0h expected src %0d tag %0d data %0h",
                              cdb_src, cdb_tag, cdb_data, e.src, e.tag, e.data);
            end
            src_cnt[cdb_src]++;
        end
    end

    task automatic expect_b(input int u, input int t, input logic [31:0] d);
        exp_t e;
        e.src = 2'(u); e.tag = 6'(t); e.data = d;
        sb.push_back(e);
    endtask

    task automatic add(input int u, input int t, input logic [31:0] d);
        ftag[u][flen[u]]  = 6'(t);
        fdata[u][flen[u]] = d;
        flen[u]++;
    endtask

    task automatic clear_feed();
        for (int u = 0; u < 4; u++) begin flen[u] = 0; fidx[u] = 0; src_cnt[u] = 0; end
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; valid = '0; tag = '0; data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Drives every feed with valid/ready handshakes; optionally checks mult
    // backpressure after the second edge.
    task automatic run_streams(input int max_cyc, input bit chk_mult);
        int  cyc = 0;
        bit  acc[4];
        bit  more = 1'b1;
        while (more && cyc < max_cyc) begin
            for (int u = 0; u < 4; u++) begin
                if (fidx[u] < flen[u]) begin
                    valid[u] = 1'b1; tag[u] = ftag[u][fidx[u]]; data[u] = fdata[u][fidx[u]];
                end else valid[u] = 1'b0;
                acc[u] = valid[u] && rdy[u];
            end
            @(posedge clk); #1;
            cyc++;
            for (int u = 0; u < 4; u++) if (acc[u]) fidx[u]++;
            if (chk_mult && cyc == 2) chk("mult_ready_full", 32'(rdy[1]), 32'd0);
            more = 1'b0;
            for (int u = 0; u < 4; u++) if (fidx[u] < flen[u]) more = 1'b1;
        end
        valid = '0;
        if (more) chk("stream_timeout", 32'(cyc), 32'(max_cyc + 1));
    endtask

    task automatic drain(input string name, input int max_cyc);
        int c = 0;
        while (sb.size() != 0 && c < max_cyc) begin @(posedge clk); c++; end
        repeat (4) @(posedge clk);
        #1 chk(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic load_two_each();
        clear_feed();
        for (int u = 0; u < 4; u++) begin
            add(u, 40 + u, mkdata(u, 40 + u));
            add(u, 44 + u, mkdata(u, 44 + u));
        end
        run_streams(10, 1'b0);
    endtask

    initial begin
        clear_feed();
        do_reset();
        chk("rst_valid", 32'(cdb_valid), 32'd0);
        chk("rst_tag",   32'(cdb_tag),   32'd0);
        chk("rst_data",  cdb_data,       32'd0);
        chk("rst_src",   32'(cdb_src),   32'd0);
        chk("rst_ready", 32'(rdy),       32'hF);
        chk("rst_busy",  32'(busy),      32'd0);

        // 1: single push
        clear_feed();
        add(0, 5, 32'hDEADBEEF);
        expect_b(0, 5, 32'hDEADBEEF);
        run_streams(5, 1'b0);
        drain("t1_drain", 20);
        chk("t1_busy", 32'(busy), 32'd0);

        // 2: four simultaneous pushes from pointer 0, then pointer-is-0 probe
        do_reset(); clear_feed();
        for (int u = 0; u < 4; u++) begin
            add(u, u + 1, mkdata(u, u + 1));
            expect_b(u, u + 1, mkdata(u, u + 1));
        end
        run_streams(5, 1'b0);
        drain("t2_drain", 20);
        clear_feed();
        add(0, 20, mkdata(0, 20)); add(1, 21, mkdata(1, 21));
        expect_b(0, 20, mkdata(0, 20)); expect_b(1, 21, mkdata(1, 21));
        run_streams(5, 1'b0);
        drain("t2_rr_end", 20);

        // 3: mult backpressure while int streams
        do_reset(); clear_feed();
        for (int k = 0; k < 4; k++) add(0, 32 + k, mkdata(0, 32 + k));
        for (int k = 0; k < 3; k++) add(1, 10 + k, mkdata(1, 10 + k));
        expect_b(0, 32, mkdata(0, 32)); expect_b(1, 10, mkdata(1, 10));
        expect_b(0, 33, mkdata(0, 33)); expect_b(1, 11, mkdata(1, 11));
        expect_b(0, 34, mkdata(0, 34)); expect_b(1, 12, mkdata(1, 12));
        expect_b(0, 35, mkdata(0, 35));
        run_streams(20, 1'b1);
        drain("t3_drain", 20);

        // 4: saturation fairness, strict rotation
        do_reset(); clear_feed();
        for (int u = 0; u < 4; u++)
            for (int k = 0; k < 10; k++) add(u, u * 16 + k, mkdata(u, u * 16 + k));
        for (int k = 0; k < 10; k++)
            for (int u = 0; u < 4; u++) expect_b(u, u * 16 + k, mkdata(u, u * 16 + k));
        run_streams(80, 1'b0);
        drain("t4_drain", 60);
        for (int u = 0; u < 4; u++) chk($sformatf("t4_grants_%0d", u), 32'(src_cnt[u]), 32'd10);

        // 5: flush with div and int pushing in the flush cycle
        do_reset();
        expect_b(0, 40, mkdata(0, 40));
        load_two_each();
        flush = 1'b1;
        valid[2] = 1'b1; tag[2] = 6'd7; data[2] = mkdata(2, 7);
        valid[0] = 1'b1; tag[0] = 6'd8; data[0] = mkdata(0, 8);
        @(posedge clk); #1;
        flush = 1'b0; valid = '0;
        chk("t5_valid", 32'(cdb_valid), 32'd0);
        chk("t5_busy",  32'(busy),      32'd0);
        chk("t5_ready", 32'(rdy),       32'hF);
        drain("t5_drain", 10);
        clear_feed();
        add(0, 50, mkdata(0, 50)); add(1, 51, mkdata(1, 51));
        expect_b(0, 50, mkdata(0, 50)); expect_b(1, 51, mkdata(1, 51));
        run_streams(5, 1'b0);
        drain("t5_rr_zero", 20);

        // 6: reset while FIFOs are full and the bus is busy
        do_reset();
        expect_b(0, 40, mkdata(0, 40));
        load_two_each();
        chk("t6_pre_valid", 32'(cdb_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_valid", 32'(cdb_valid), 32'd0);
        chk("t6_tag",   32'(cdb_tag),   32'd0);
        chk("t6_data",  cdb_data,       32'd0);
        chk("t6_src",   32'(cdb_src),   32'd0);
        chk("t6_ready", 32'(rdy),       32'hF);
        chk("t6_busy",  32'(busy),      32'd0);
        rst = 1'b0;
        drain("t6_drain", 10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Downstream of the issue stage: consumes the four per-unit submit streams (int, mult, div, mem) and serialises them onto the single common data bus (CDB).
- Each unit owns a small result FIFO, so units that finish in the same cycle do not stall each other.
- A round-robin arbiter picks one non-empty FIFO per cycle and drives a registered CDB broadcast to the reservation stations and the ROB.

Parameters:
TAG_W, 6, ROB/physical tag width carried with each result
DATA_W, 32, result data width
DEPTH, 2, per-unit result FIFO depth (power of 2, >=2)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_flush  in  1  pipeline flush; discards all buffered results
i_int_valid  in  1  int unit result valid
i_int_tag  in  TAG_W  int result tag
i_int_data  in  DATA_W  int result data
o_int_ready  out  1  int FIFO can accept
i_mult_valid / i_mult_tag / i_mult_data / o_mult_ready  -  same as int, mult unit
i_div_valid / i_div_tag / i_div_data / o_div_ready  -  same as int, div unit
i_mem_valid / i_mem_tag / i_mem_data / o_mem_ready  -  same as int, mem unit
o_cdb_valid  out  1  broadcast valid this cycle
o_cdb_tag  out  TAG_W  broadcast tag
o_cdb_data  out  DATA_W  broadcast data
o_cdb_src  out  2  source unit: 0 int, 1 mult, 2 div, 3 mem
o_busy  out  1  any FIFO non-empty

Behaviour:
- Reset (i_rst high at an edge): all FIFOs empty; all read/write pointers 0; RR pointer = 0 (int); o_cdb_valid=0, o_cdb_tag=0, o_cdb_data=0, o_cdb_src=0; all o_*_ready=1; o_busy=0. Reset overrides flush, push and pop.
- Push: unit u is written at an edge where i_u_valid && o_u_ready.
  - o_u_ready = !full_u, combinational from FIFO state only. It does not depend on the same-cycle pop, so there is no bypass.
  - A unit holds valid/tag/data until ready is seen.
- FIFO: count width clog2(DEPTH)+1. Pointers wrap modulo DEPTH. Simultaneous push and pop on a non-empty, non-full FIFO leaves count unchanged.
- Arbitration (combinational, each cycle):
  - Request r_u = FIFO u non-empty.
  - Search starts at the RR pointer p and proceeds p, p+1, ..., p+3 mod 4. The first requester is granted, g.
  - At the edge, FIFO g is popped, its head is loaded into the CDB registers with o_cdb_src=g, and p <= (g+1) mod 4.
  - With no requester: o_cdb_valid <= 0, tag/data/src hold their previous values, and p is unchanged.
- Latency: a result pushed at edge k appears on the CDB at the earliest in the cycle after edge k+1 (2 edges from valid-and-ready). There is no same-cycle pass-through.
- Throughput: 1 result per cycle total. A unit with a continuously full FIFO receives at least 1 grant per 4 cycles (starvation-free).
- o_cdb_valid is high for exactly one cycle per result. Each pushed result is broadcast exactly once, and results from one unit keep FIFO order.
- Flush (i_flush high at an edge, no reset):
  - All FIFOs are emptied and any push in that cycle is dropped.
  - No pop occurs; o_cdb_valid <= 0 and p <= 0.
  - Readies return to 1 in the next cycle.
- o_busy = OR of the non-empty flags (combinational).

Test Plan:
1. Reset then single push: int valid, tag=5, data=0xDEADBEEF at edge 1 -> o_cdb_valid=1 with tag 5, data 0xDEADBEEF, src 0 during the cycle after edge 2 only; then o_busy=0.
2. All four push in the same cycle (tags 1,2,3,4), RR pointer 0 -> CDB sequence over 4 consecutive cycles: tags 1,2,3,4, src 0,1,2,3; RR pointer ends at 0.
3. Backpressure: mult pushes tags 10,11,12 back-to-back with DEPTH=2 while int holds the bus, i.e. int continuously pushes -> o_mult_ready=0 after two pushes; tag 12 is held by the unit and accepted later. CDB order from mult is 10,11,12; with int saturating, mult is granted at least every 2nd cycle.
4. Fairness under saturation: all four valid every cycle for 40 cycles -> each src granted exactly 10 times, strict rotation 0,1,2,3.
5. Flush mid-stream: load 2 results in each FIFO, assert i_flush for one cycle while div also pushes tag 7 -> next cycle o_cdb_valid=0, o_busy=0, all readies 1. Tag 7 never appears on the CDB.
6. Reset mid-operation: i_rst while FIFOs are full and o_cdb_valid=1 -> next cycle all outputs at their reset values. No stale result is broadcast afterwards.
